// File: rtl/yutorina_bus_arbiter_pkg.sv
// rtl/yutorina_bus_arbiter_pkg.sv - shared bus definitions: master count, index width, arbiter states, reset values
package yutorina_bus_arbiter_pkg;

    localparam int N_MASTERS = 4;
    localparam int IDX_W     = 2;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Bus read/write encoding on *_rw.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam arb_state_t             STATE_RST = IDLE;
    localparam idx_t                   PTR_RST   = '0;
    localparam logic [N_MASTERS-1:0]   GRNT_RST  = '1;
    localparam logic [N_MASTERS-1:0]   RDY_RST   = '1;

endpackage

// File: rtl/yutorina_rr_pick.sv
// rtl/yutorina_rr_pick.sv - combinational 4-way round-robin search from a start index
//
// Ports:
//   req   in  N_MASTERS  active-high request vector
//   start in  IDX_W      first index examined; search wraps start, start+1, ...
//   valid out 1          some request was found
//   idx   out IDX_W      first requesting index in search order (start when none)
module yutorina_rr_pick
    import yutorina_bus_arbiter_pkg::*;
(
    input  logic [N_MASTERS-1:0] req,
    input  idx_t                 start,
    output logic                 valid,
    output idx_t                 idx
);

    idx_t cand;

    // Scan from the farthest offset down to offset 0 so the nearest
    // requester in search order is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            cand = start + idx_t'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// rtl/yutorina_bus_arbiter.sv - 4-master round-robin bus arbiter with shared slave bus mux
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   m_req_[3:0]      in   active-low per-master request
//   m_grnt_[3:0]     out  active-low per-master grant (registered)
//   m_addr/m_as_/m_rw/m_w_data  in  per-master transaction signals
//   m_rdy_[3:0]      out  active-low per-master ready (owner sees s_rdy_)
//   m_r_data         out  slave read data broadcast to all masters
//   s_addr/s_as_/s_rw/s_w_data  out shared slave bus driven by the owner
//   s_rdy_, s_r_data in   slave ready (active-low) and read data
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_MASTERS-1:0]              m_req_,
    output logic [N_MASTERS-1:0]              m_grnt_,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0]  m_addr,
    input  logic [N_MASTERS-1:0]              m_as_,
    input  logic [N_MASTERS-1:0]              m_rw,
    input  logic [N_MASTERS-1:0][DATA_W-1:0]  m_w_data,
    output logic [N_MASTERS-1:0]              m_rdy_,
    output logic [DATA_W-1:0]                 m_r_data,
    output logic [ADDR_W-1:0]                 s_addr,
    output logic                              s_as_,
    output logic                              s_rw,
    output logic [DATA_W-1:0]                 s_w_data,
    input  logic                              s_rdy_,
    input  logic [DATA_W-1:0]                 s_r_data
);

    arb_state_t           state, state_n;
    idx_t                 owner, owner_n;
    idx_t                 ptr, ptr_n;
    logic [N_MASTERS-1:0] grnt_n;

    idx_t                 pick_start;
    logic                 pick_valid;
    idx_t                 pick_idx;

    // IDLE searches from the round-robin pointer; on release the search
    // starts just past the old owner, so the old owner comes last and a
    // one-cycle release hands the bus away whenever anyone else waits.
    assign pick_start = (state == IDLE) ? ptr : owner + idx_t'(1);

    yutorina_rr_pick u_pick (
        .req   (~m_req_),
        .start (pick_start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STATE_RST;
            owner   <= PTR_RST;
            ptr     <= PTR_RST;
            m_grnt_ <= GRNT_RST;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            m_grnt_ <= grnt_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = OWNED;
                    owner_n = pick_idx;
                end
            end
            OWNED: begin
                if (m_req_[owner]) begin
                    ptr_n = owner + idx_t'(1);
                    if (pick_valid) begin
                        owner_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Grant is computed from the next state so the register holds
        // exactly one low bit while owned and all ones when idle.
        grnt_n = GRNT_RST;
        if (state_n == OWNED) begin
            grnt_n[owner_n] = 1'b0;
        end
    end

    always_comb begin
        s_addr   = '0;
        s_as_    = 1'b1;
        s_rw     = RW_READ;
        s_w_data = '0;
        m_rdy_   = RDY_RST;
        if (state == OWNED) begin
            s_addr         = m_addr[owner];
            s_as_          = m_as_[owner];
            s_rw           = m_rw[owner];
            s_w_data       = m_w_data[owner];
            m_rdy_[owner]  = s_rdy_;
        end
    end

    assign m_r_data = s_r_data;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// tb/tb_yutorina_bus_arbiter.sv - self-checking scoreboard bench for yutorina_bus_arbiter
module tb_yutorina_bus_arbiter;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        m_req_ = 4'b1111;
    logic [3:0]        m_grnt_;
    logic [3:0][29:0]  m_addr;
    logic [3:0]        m_as_;
    logic [3:0]        m_rw;
    logic [3:0][31:0]  m_w_data;
    logic [3:0]        m_rdy_;
    logic [31:0]       m_r_data;
    logic [29:0]       s_addr;
    logic              s_as_;
    logic              s_rw;
    logic [31:0]       s_w_data;
    logic              s_rdy_ = 1'b1;
    logic [31:0]       s_r_data = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the arbiter and the scoreboard of expected grants.
    logic       mvalid = 1'b0;
    int         mown   = 0;
    int         mptr   = 0;
    logic [3:0] exp_q[$];

    yutorina_bus_arbiter #(.ADDR_W(30), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req_   (m_req_),
        .m_grnt_  (m_grnt_),
        .m_addr   (m_addr),
        .m_as_    (m_as_),
        .m_rw     (m_rw),
        .m_w_data (m_w_data),
        .m_rdy_   (m_rdy_),
        .m_r_data (m_r_data),
        .s_addr   (s_addr),
        .s_as_    (s_as_),
        .s_rw     (s_rw),
        .s_w_data (s_w_data),
        .s_rdy_   (s_rdy_),
        .s_r_data (s_r_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end (got running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] model_grant();
        logic [3:0] g;
        g = 4'b1111;
        if (mvalid) g[mown] = 1'b0;
        return g;
    endfunction

    // Advance the model by one clock edge using the request vector now applied.
    task automatic model_edge();
        int start;
        int first;
        bit found;
        if (!mvalid) begin
            start = mptr;
        end else if (m_req_[mown]) begin
            start = (mown + 1) % 4;
            mptr  = start;
        end else begin
            return;
        end
        found = 0;
        first = 0;
        for (int k = 0; k < 4; k++) begin
            if (!found && !m_req_[(start + k) % 4]) begin
                found = 1;
                first = (start + k) % 4;
            end
        end
        mvalid = found;
        if (found) mown = first;
    endtask

    task automatic check_bus(input string tag);
        logic [3:0] er;
        er = 4'b1111;
        if (mvalid) er[mown] = s_rdy_;
        check({tag, ".s_addr"},   s_addr,   mvalid ? m_addr[mown]   : 30'h0);
        check({tag, ".s_as_"},    s_as_,    mvalid ? m_as_[mown]    : 1'b1);
        check({tag, ".s_rw"},     s_rw,     mvalid ? m_rw[mown]     : 1'b1);
        check({tag, ".s_w_data"}, s_w_data, mvalid ? m_w_data[mown] : 32'h0);
        check({tag, ".m_rdy_"},   m_rdy_,   er);
        check({tag, ".m_r_data"}, m_r_data, s_r_data);
    endtask

    // One clock: expected grant is queued at drive time and compared after the edge.
    task automatic step(input string tag);
        model_edge();
        exp_q.push_back(model_grant());
        @(posedge clk);
        #1;
        check({tag, ".grnt"}, m_grnt_, exp_q.pop_front());
        check_bus(tag);
    endtask

    task automatic do_reset();
        m_req_ = 4'b1111;
        rst = 1'b1;
        mvalid = 1'b0;
        mptr = 0;
        mown = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_addr[i]   = 30'h100 + 30'(i * 'h11);
            m_w_data[i] = 32'hA000_0000 + 32'(i * 'h1234);
            m_as_[i]    = i[0];
            m_rw[i]     = ~i[1];
        end

        // Reset state
        @(posedge clk);
        #1;
        check("rst.grnt", m_grnt_, 4'b1111);
        check_bus("rst");
        rst = 1'b0;

        // Single request from master 0
        m_req_ = 4'b1110;
        step("single0");
        check("single0.addr0", s_addr, m_addr[0]);
        m_req_ = 4'b1111;
        step("single0.rel");

        // All four request from ptr=0, each holds 3 cycles
        do_reset();
        m_req_ = 4'b0000;
        step("all.first");
        for (int m = 0; m < 4; m++) begin
            step("all.hold");
            step("all.hold");
            m_req_[m] = 1'b1;
            step("all.handoff");
            check("all.onehot", 64'($countones(~m_grnt_) <= 1), 64'd1);
        end

        // No preemption: owner 2 holds while master 1 waits
        do_reset();
        m_req_ = 4'b1011;
        step("hold.own2");
        m_req_[1] = 1'b0;
        for (int i = 0; i < 10; i++) step("hold.wait");
        m_req_[2] = 1'b1;
        step("hold.to1");
        check("hold.grant1", m_grnt_, 4'b1101);
        m_req_ = 4'b1111;
        step("hold.idle");
        m_req_ = 4'b0000;
        step("hold.ptr2");

        // Wrap: owner 3 releases with only master 0 waiting
        do_reset();
        m_req_ = 4'b0111;
        step("wrap.own3");
        m_req_ = 4'b0110;
        step("wrap.hold");
        m_req_ = 4'b1110;
        step("wrap.to0");
        check("wrap.grant0", m_grnt_, 4'b1110);
        // One-cycle release with others waiting loses the bus
        m_req_ = 4'b0001;
        step("relreq.to1");
        m_req_ = 4'b0000;
        step("relreq.keep1");

        // Owner 1 mid-transaction sees slave ready and read data
        s_r_data = 32'hDEAD_BEEF;
        s_rdy_ = 1'b0;
        step("rdy.low");
        check("rdy.vec", m_rdy_, 4'b1101);
        s_rdy_ = 1'b1;
        s_r_data = 32'h1357_9BDF;
        step("rdy.high");

        // Asynchronous reset while master 2 owns
        do_reset();
        m_req_ = 4'b1011;
        step("arst.own2");
        m_req_ = 4'b1110;
        #2;
        rst = 1'b1;
        #1;
        check("arst.grnt", m_grnt_, 4'b1111);
        check("arst.s_as_", s_as_, 1'b1);
        check("arst.s_addr", s_addr, 30'h0);
        check("arst.m_rdy_", m_rdy_, 4'b1111);
        mvalid = 1'b0;
        mptr = 0;
        #1;
        rst = 1'b0;
        step("arst.to0");
        check("arst.grant0", m_grnt_, 4'b1110);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
